// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: 2-entry in-order queue, branch squash, fetch timeout.
// Optional stall performance counter port o_stall_count enabled by FETCH_PERF_CNT_EN.
//
// state  | meaning
// IDLE   | one cycle after reset release, no request
// FETCH  | issuing requests and pushing returned words into the queue
// SQUASH | branch taken while a request was pending; wait for it and drop the data
// ERROR  | memory timed out; requests stopped until reset
module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_address,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_data,
    output logic        o_mem_req,
    output logic [31:0] o_mem_address,
    output logic        o_valid,
    output logic [31:0] o_address,
    output logic [31:0] o_instruccion,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] o_stall_count,
`endif
    output logic        o_error
);

    localparam int TW = (TIMEOUT_CYCLES < 3) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SQUASH, ERROR} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [63:0]   head_q, head_d;
    logic [63:0]   skid_q, skid_d;

    logic        push, pop, flush, timeout, waiting;
    logic [31:0] target;
    logic [63:0] new_entry;

    assign target    = {i_branch_address[31:2], 2'b00};
    assign new_entry = {addr_q, i_mem_data};
    assign waiting   = req_q && !i_mem_ready;
    assign timeout   = waiting && (tmo_q == TMO_LAST);
    assign pop       = (cnt_q != 2'd0) && !i_stall;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        tmo_d   = waiting ? tmo_q + 1'b1 : '0;
        push    = 1'b0;
        flush   = 1'b0;
        cnt_d   = cnt_q;
        head_d  = head_q;
        skid_d  = skid_q;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (timeout) begin
                    state_d = ERROR;
                    flush   = 1'b1;
                end else if (i_branch_taken) begin
                    flush = 1'b1;
                    pc_d  = target;
                    if (waiting) state_d = SQUASH;
                end else if (req_q && i_mem_ready) begin
                    push = 1'b1;
                    pc_d = pc_q + 32'd4;
                end
            end
            SQUASH: begin
                if (timeout) begin
                    state_d = ERROR;
                    flush   = 1'b1;
                end else begin
                    if (i_branch_taken) begin
                        flush = 1'b1;
                        pc_d  = target;
                    end
                    if (i_mem_ready) state_d = FETCH;
                end
            end
            ERROR: begin
                flush = 1'b1;
                tmo_d = '0;
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            cnt_d = 2'd0;
        end else if (push && pop) begin
            if (cnt_q == 2'd1) begin
                head_d = new_entry;
            end else begin
                head_d = skid_q;
                skid_d = new_entry;
            end
        end else if (push) begin
            if (cnt_q == 2'd0) head_d = new_entry;
            else               skid_d = new_entry;
            cnt_d = cnt_q + 2'd1;
        end else if (pop) begin
            head_d = skid_q;
            cnt_d  = cnt_q - 2'd1;
        end

        // A pending request is held untouched; a new one issues only with queue room.
        if (state_d == ERROR || state_q == IDLE || state_q == ERROR) begin
            req_d = 1'b0;
        end else if (waiting) begin
            req_d = 1'b1;
        end else if (cnt_d < 2'd2) begin
            req_d  = 1'b1;
            addr_d = pc_d;
        end else begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
            req_q   <= 1'b0;
            addr_q  <= RESET_VECTOR;
            tmo_q   <= '0;
            cnt_q   <= 2'd0;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (o_valid && i_stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
    end

    assign o_stall_count = stall_cnt_q;
`endif

    assign o_mem_req     = req_q;
    assign o_mem_address = addr_q;
    assign o_valid       = (cnt_q != 2'd0);
    assign o_address     = head_q[63:32];
    assign o_instruccion = head_q[31:0];
    assign o_error       = (state_q == ERROR);

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum cycles a memory request may wait for i_mem_ready.
REQ-003 SHALL have port i_clock  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_stall  in  1  decode stage cannot accept the presented instruction.
REQ-006 SHALL have port i_branch_taken  in  1  single-cycle redirect request.
REQ-007 SHALL have port i_branch_address  in  32  redirect target; bits [1:0] ignored and treated as 00.
REQ-008 SHALL have port i_mem_ready  in  1  instruction memory returns i_mem_data this cycle.
REQ-009 SHALL have port i_mem_data  in  32  fetched instruction word.
REQ-010 SHALL have port o_mem_req  out  1  instruction memory read request.
REQ-011 SHALL have port o_mem_address  out  32  address of the outstanding request, registered.
REQ-012 SHALL have port o_valid  out  1  o_address/o_instruccion hold a valid instruction.
REQ-013 SHALL have port o_address  out  32  PC of the presented instruction.
REQ-014 SHALL have port o_instruccion  out  32  presented instruction word.
REQ-015 SHALL have port o_error  out  1  sticky fetch timeout flag.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, SQUASH, ERROR; IDLE lasts exactly one cycle after reset release, then FETCH.
REQ-017 SHALL hold a 2-entry in-order queue: head drives o_valid/o_address/o_instruccion; the second entry is a skid slot.
REQ-018 SHALL pop the head on every cycle with o_valid=1 and i_stall=0; the skid entry moves to head on the same edge.
REQ-019 SHALL assert o_mem_req in FETCH and SQUASH only, and only while queue count < 2 at the start of the cycle.
REQ-020 SHALL keep o_mem_req and o_mem_address stable from assertion until the cycle i_mem_ready=1, except on entry to ERROR.
REQ-021 SHALL, in FETCH with i_mem_ready=1, push {o_mem_address, i_mem_data} and advance PC by 4; next request issues the following cycle (throughput 1 per cycle with zero-wait memory).
REQ-022 SHALL perform PC addition modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-023 SHALL, on i_branch_taken=1, clear the queue (o_valid=0 next cycle) and load PC with {i_branch_address[31:2],2'b00}; branch has priority over i_stall and over a same-cycle push.
REQ-024 SHALL, on a branch with a request outstanding and i_mem_ready=0, enter SQUASH: hold the old request until i_mem_ready, discard that data, then FETCH at the new PC.
REQ-025 SHALL, on a branch coinciding with i_mem_ready=1, discard the returned data and request the branch target the next cycle.
REQ-026 SHALL accept the latest branch while in SQUASH (PC overwritten, data still discarded); branches in ERROR are ignored.
REQ-027 SHALL count consecutive cycles o_mem_req=1 with i_mem_ready=0; on reaching TIMEOUT_CYCLES enter ERROR: o_mem_req=0, o_valid=0, o_error=1 until reset.

Reset
REQ-028 SHALL, while i_reset=0, force state IDLE, PC=RESET_VECTOR, o_mem_address=RESET_VECTOR, o_mem_req=0, o_valid=0, o_address=0, o_instruccion=0, o_error=0, queue count 0, timeout counter 0.
REQ-029 SHALL abandon any outstanding request on reset assertion mid-transaction; the memory is reset by the same signal.

Configuration
REQ-030 SHALL, with FETCH_PERF_CNT_EN defined, add port o_stall_count out 32: cycles with o_valid=1 and i_stall=1, saturating at 32'hFFFF_FFFF, reset to 0, not cleared by branches.
REQ-031 SHALL, without FETCH_PERF_CNT_EN, omit o_stall_count and its counter entirely; all other behaviour identical.

Verification
REQ-032 Reset release, memory always ready, i_stall=0 -> o_mem_address 0,4,8,... one per cycle; first o_valid=1 with o_address=0 three cycles after release.
REQ-033 i_stall=1 for 5 cycles with zero-wait memory -> queue fills to 2, o_mem_req drops, head held stable; on release both entries emitted in order, none lost or duplicated.
REQ-034 Branch to 32'h0000_0103 while request to 32'h10 waits 3 cycles -> SQUASH, data for 32'h10 never presented, next o_mem_address=32'h0000_0100.
REQ-035 PC=32'hFFFF_FFFC fetched -> next o_mem_address=32'h0000_0000.
REQ-036 i_mem_ready held 0 for 16 cycles -> o_error=1, o_mem_req=0, o_valid=0; stays so until i_reset=0.
REQ-037 With FETCH_PERF_CNT_EN, i_stall=1 for 7 cycles with o_valid=1 -> o_stall_count=7.
